// File: rtl/fft_peak_picker.sv
// Per-frame peak search over the FFT output stream: |re|+|im| magnitude, windowed
// strict-greater maximum, registered result with frame validation and good-frame count.
module fft_peak_picker #(
   parameter int FFT_POINTS = 8192,
   parameter int BIN_W      = 13,
   parameter int DATA_W     = 32,
   parameter int MIN_BIN    = 2,
   parameter int MAX_BIN    = 4095,
   parameter int THRESHOLD  = 4096
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              source_valid,
   input  logic              source_sop,
   input  logic              source_eop,
   input  logic [DATA_W-1:0] source_real,
   input  logic [DATA_W-1:0] source_imag,
   output logic              source_ready,
   output logic              result_valid,
   output logic [BIN_W-1:0]  peak_bin,
   output logic [DATA_W:0]   peak_mag,
   output logic              signal_present,
   output logic              frame_error,
   output logic [15:0]       frame_count
);

   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_POINTS - 1);
   localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(MIN_BIN);
   localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(MAX_BIN);
   localparam logic [DATA_W:0]  THR      = (DATA_W+1)'(THRESHOLD);

   typedef enum logic {IDLE, IN_FRAME} state_t;

   state_t           state_reg, state_next;
   logic [BIN_W-1:0] bin_reg, bin_next, beat_bin;
   logic             take, tag_first, tag_last, tag_abort, err_next;

   // Stage 0: captured beat and tags
   logic                     v0, first0, last0, abort0, win0;
   logic [BIN_W-1:0]         bin0;
   logic [1:0][DATA_W-1:0]   raw0;
   logic [1:0][DATA_W-1:0]   abs_val;
   // Stage 1: absolute values
   logic                     v1, first1, last1, abort1, win1;
   logic [BIN_W-1:0]         bin1;
   logic [1:0][DATA_W-1:0]   abs1;
   // Stage 2: magnitude
   logic                     v2, first2, last2, abort2, win2;
   logic [BIN_W-1:0]         bin2;
   logic [DATA_W:0]          mag2;
   // Stage 3: running best
   logic [DATA_W:0]          best_mag_reg, cur_mag;
   logic [BIN_W-1:0]         best_bin_reg, cur_bin;

   assign source_ready = ~reset;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         bin_reg   <= '0;
      end else begin
         state_reg <= state_next;
         bin_reg   <= bin_next;
      end
   end

   // A sop always restarts at bin 0; mid-frame it also flags the abandoned frame.
   always_comb begin
      state_next = state_reg;
      bin_next   = bin_reg;
      beat_bin   = bin_reg + BIN_W'(1);
      take       = 1'b0;
      tag_first  = 1'b0;
      tag_last   = 1'b0;
      tag_abort  = 1'b0;
      err_next   = 1'b0;
      if (source_valid) begin
         if (source_sop) begin
            beat_bin  = '0;
            take      = 1'b1;
            tag_first = 1'b1;
            err_next  = (state_reg == IN_FRAME);
         end else if (state_reg == IN_FRAME) begin
            take = 1'b1;
         end
         if (take) begin
            bin_next   = beat_bin;
            state_next = IN_FRAME;
            if (beat_bin == LAST_BIN) begin
               state_next = IDLE;
               if (source_eop) begin
                  tag_last = 1'b1;
               end else begin
                  err_next  = 1'b1;
                  tag_abort = 1'b1;
               end
            end else if (source_eop) begin
               state_next = IDLE;
               err_next   = 1'b1;
               tag_abort  = 1'b1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign abs_val[gi] = raw0[gi][DATA_W-1] ? (~raw0[gi] + DATA_W'(1)) : raw0[gi];
      end
   endgenerate

   always_comb begin
      cur_mag = first2 ? '0 : best_mag_reg;
      cur_bin = first2 ? LO_BIN : best_bin_reg;
      if (win2 && (mag2 > cur_mag)) begin
         cur_mag = mag2;
         cur_bin = bin2;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         v0 <= 1'b0; first0 <= 1'b0; last0 <= 1'b0; abort0 <= 1'b0; win0 <= 1'b0;
         bin0 <= '0; raw0 <= '0;
         v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0; abort1 <= 1'b0; win1 <= 1'b0;
         bin1 <= '0; abs1 <= '0;
         v2 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0; abort2 <= 1'b0; win2 <= 1'b0;
         bin2 <= '0; mag2 <= '0;
         best_mag_reg   <= '0;
         best_bin_reg   <= '0;
         result_valid   <= 1'b0;
         peak_bin       <= '0;
         peak_mag       <= '0;
         signal_present <= 1'b0;
         frame_error    <= 1'b0;
         frame_count    <= '0;
      end else begin
         frame_error <= err_next;
         v0     <= take;
         first0 <= tag_first;
         last0  <= tag_last;
         abort0 <= tag_abort;
         win0   <= (beat_bin >= LO_BIN) && (beat_bin <= HI_BIN);
         bin0   <= beat_bin;
         raw0   <= {source_imag, source_real};

         v1 <= v0; first1 <= first0; last1 <= last0; abort1 <= abort0; win1 <= win0;
         bin1 <= bin0;
         abs1 <= abs_val;

         v2 <= v1; first2 <= first1; last2 <= last1; abort2 <= abort1; win2 <= win1;
         bin2 <= bin1;
         mag2 <= {1'b0, abs1[0]} + {1'b0, abs1[1]};

         result_valid <= 1'b0;
         if (v2) begin
            best_mag_reg <= abort2 ? '0 : cur_mag;
            best_bin_reg <= abort2 ? LO_BIN : cur_bin;
            if (last2 && !abort2) begin
               result_valid   <= 1'b1;
               peak_bin       <= cur_bin;
               peak_mag       <= cur_mag;
               signal_present <= (cur_mag >= THR);
               frame_count    <= frame_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_picker.sv
// Directed bench for fft_peak_picker: a per-beat model builds expected peaks,
// queued per good frame and popped by a monitor when result_valid pulses.
module tb_fft_peak_picker;

   localparam int N         = 8192;
   localparam int MIN_BIN   = 2;
   localparam int MAX_BIN   = 4095;
   localparam int THRESHOLD = 4096;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic        source_valid, source_sop, source_eop;
   logic [31:0] source_real, source_imag;
   logic        source_ready, result_valid, signal_present, frame_error;
   logic [12:0] peak_bin;
   logic [32:0] peak_mag;
   logic [15:0] frame_count;

   typedef struct {
      int          bin;
      longint      mag;
      bit          present;
      logic [15:0] count;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   err_pulses = 0;
   int   exp_count = 0;
   int   e0;
   int   sp_re[int];
   int   sp_im[int];

   fft_peak_picker dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .source_valid  (source_valid),
      .source_sop    (source_sop),
      .source_eop    (source_eop),
      .source_real   (source_real),
      .source_imag   (source_imag),
      .source_ready  (source_ready),
      .result_valid  (result_valid),
      .peak_bin      (peak_bin),
      .peak_mag      (peak_mag),
      .signal_present(signal_present),
      .frame_error   (frame_error),
      .frame_count   (frame_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint labs(input int v);
      longint x;
      x = longint'(v);
      return (x < 0) ? -x : x;
   endfunction

   // Drives nbeats beats starting with sop; the model tracks the expected peak.
   task automatic send_frame(input int nbeats, input bit do_eop, input bit gaps);
      longint best_mag, m;
      int     best_bin, re, im;
      exp_t   e;
      best_mag = 0;
      best_bin = MIN_BIN;
      for (int b = 0; b < nbeats; b++) begin
         if (gaps) begin
            while ($urandom_range(15) == 0) begin
               @(negedge CLOCK_50);
               source_valid = 1'b0;
               source_sop   = 1'($urandom);
               source_eop   = 1'($urandom);
               source_real  = $urandom;
               source_imag  = $urandom;
            end
         end
         re = sp_re.exists(b) ? sp_re[b] : 0;
         im = sp_im.exists(b) ? sp_im[b] : 0;
         @(negedge CLOCK_50);
         source_valid = 1'b1;
         source_sop   = (b == 0);
         source_eop   = do_eop && (b == nbeats - 1);
         source_real  = re;
         source_imag  = im;
         m = labs(re) + labs(im);
         if (b >= MIN_BIN && b <= MAX_BIN && m > best_mag) begin
            best_mag = m;
            best_bin = b;
         end
      end
      if (do_eop && nbeats == N) begin
         exp_count++;
         e.bin     = best_bin;
         e.mag     = best_mag;
         e.present = (best_mag >= THRESHOLD);
         e.count   = 16'(exp_count);
         sb.push_back(e);
         last_exp  = e;
      end
   endtask

   task automatic idle_inputs();
      source_valid = 1'b0;
      source_sop   = 1'b0;
      source_eop   = 1'b0;
   endtask

   task automatic expect_result(input string tag);
      for (int k = 0; k < 6; k++) begin
         @(negedge CLOCK_50);
         if (k == 0) idle_inputs();
         chk({tag, "_result_valid"}, 64'(result_valid), 64'(k == 3));
         chk({tag, "_no_frame_error"}, 64'(frame_error), 64'd0);
      end
   endtask

   task automatic expect_error(input string tag);
      for (int k = 0; k < 6; k++) begin
         @(negedge CLOCK_50);
         if (k == 0) idle_inputs();
         chk({tag, "_frame_error"}, 64'(frame_error), 64'(k == 0));
         chk({tag, "_no_result"}, 64'(result_valid), 64'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_result_valid"}, 64'(result_valid), 64'd0);
      chk({tag, "_peak_bin"}, 64'(peak_bin), 64'd0);
      chk({tag, "_peak_mag"}, 64'(peak_mag), 64'd0);
      chk({tag, "_signal_present"}, 64'(signal_present), 64'd0);
      chk({tag, "_frame_error"}, 64'(frame_error), 64'd0);
      chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
      chk({tag, "_source_ready"}, 64'(source_ready), 64'd0);
   endtask

   // Scoreboard side: every result pulse must match the oldest queued frame.
   always @(negedge CLOCK_50) begin
      if (frame_error === 1'b1) err_pulses++;
      if (result_valid === 1'b1) begin
         chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("peak_bin", 64'(peak_bin), 64'(mon_e.bin));
            chk("peak_mag", 64'(peak_mag), 64'(mon_e.mag));
            chk("signal_present", 64'(signal_present), 64'(mon_e.present));
            chk("frame_count", 64'(frame_count), 64'(mon_e.count));
            $display("result bin=%0d mag=%0d present=%0b count=%0d",
                     peak_bin, peak_mag, signal_present, frame_count);
         end
      end
   end

   initial begin
      #4000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      source_real = '0;
      source_imag = '0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("ready_after_reset", 64'(source_ready), 64'd1);

      // 1: single tone at bin 100
      sp_re.delete(); sp_im.delete();
      sp_re[100] = 5000; sp_im[100] = -3000;
      send_frame(N, 1'b1, 1'b0);
      expect_result("t1");

      // 2: large bins outside the window, small one inside
      sp_re.delete(); sp_im.delete();
      sp_re[1] = 1 << 20; sp_re[5000] = 1 << 20; sp_re[300] = 10;
      send_frame(N, 1'b1, 1'b0);
      expect_result("t2");

      // 3: most negative real value beats a tie at 50/60
      sp_re.delete(); sp_im.delete();
      sp_re[40] = 32'h8000_0000;
      sp_re[50] = 4500; sp_im[50] = 4500;
      sp_re[60] = 9000;
      send_frame(N, 1'b1, 1'b0);
      expect_result("t3");

      // 4: early eop, outputs hold; then window-edge / threshold-edge frame
      sp_re.delete(); sp_im.delete();
      sp_re[10] = 7;
      send_frame(4001, 1'b1, 1'b0);
      expect_error("t4");
      chk("t4_hold_bin", 64'(peak_bin), 64'(last_exp.bin));
      chk("t4_hold_mag", 64'(peak_mag), 64'(last_exp.mag));
      chk("t4_hold_present", 64'(signal_present), 64'(last_exp.present));
      chk("t4_hold_count", 64'(frame_count), 64'(last_exp.count));
      sp_re.delete(); sp_im.delete();
      sp_re[2] = -4095; sp_re[4095] = 4096; sp_re[4096] = 100000;
      send_frame(N, 1'b1, 1'b0);
      expect_result("t4b");

      // 5: sop mid-frame at bin 1234, second frame runs back-to-back
      e0 = err_pulses;
      sp_re.delete(); sp_im.delete();
      sp_re[500] = 1000000;
      send_frame(1234, 1'b0, 1'b0);
      sp_re.delete(); sp_im.delete();
      sp_re[700] = 2000; sp_im[700] = 2000;
      send_frame(N, 1'b1, 1'b0);
      expect_result("t5");
      chk("t5_error_pulses", 64'(err_pulses - e0), 64'd1);

      // 6: reset mid-frame with gaps, then a clean gapped frame
      sp_re.delete(); sp_im.delete();
      sp_re[3000] = 50000;
      send_frame(6001, 1'b0, 1'b1);
      #5 reset = 1'b1;
      #1 check_all_zero("t6_reset");
      @(negedge CLOCK_50);
      idle_inputs();
      @(negedge CLOCK_50);
      reset = 1'b0;
      exp_count = 0;
      chk("t6_sb_empty", 64'(sb.size()), 64'd0);
      sp_re.delete(); sp_im.delete();
      sp_re[1] = 1000000; sp_re[50] = 9000; sp_im[60] = -9000;
      send_frame(N, 1'b1, 1'b1);
      expect_result("t6");

      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("total_error_pulses", 64'(err_pulses), 64'd2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
